// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } ifu_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO of fetch entries. Push and pop may coincide at any
// occupancy; flush empties the FIFO and overrides both.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests under a credit
// limit and buffers responses for decode. IFU_PERF_EN adds perf counters.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    ifu_state_t    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   tag_q [FIFO_DEPTH];
    logic [31:0]   tag_d [FIFO_DEPTH];
    logic [PW-1:0] tag_wr_q, tag_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;

    fetch_entry_t  fifo_head, fifo_push_data;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic          credit_ok, req_fire, rsp_seen, rsp_accept, pop;
    logic          unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    // Every outstanding request owns a FIFO slot, so a returning response always fits.
    assign credit_ok      = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req_valid = (state_q == RUN) && credit_ok && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_seen       = imem_rsp_valid && (inflight_q != '0);
    assign rsp_accept     = rsp_seen && (state_q == RUN) && !redirect_valid;
    assign pop            = if_valid && if_ready && !redirect_valid;
    assign fifo_push_data = {tag_q[tag_rd_q], imem_rsp_data};

    assign if_valid = !fifo_empty;
    assign if_pc    = if_valid ? fifo_head.pc    : 32'h0;
    assign if_instr = if_valid ? fifo_head.instr : NOP_INSTR;

    ifu_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (rsp_accept),
        .push_data(fifo_push_data),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_seen);
        drop_d     = drop_q;
        tag_d      = tag_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        if (req_fire) begin
            fetch_pc_d      = fetch_pc_q + 32'd4;
            tag_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d        = tag_wr_q + PW'(1);
        end
        if (rsp_accept) begin
            tag_rd_d = tag_rd_q + PW'(1);
        end
        // Whatever is still outstanding after a redirect belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            tag_wr_d   = '0;
            tag_rd_d   = '0;
            drop_d     = inflight_q - CW'(rsp_seen);
        end else if ((state_q == FLUSH) && rsp_seen) begin
            drop_d = drop_q - CW'(1);
        end
        case (state_q)
            BOOT:    state_d = RUN;
            default: state_d = (drop_d != '0) ? FLUSH : RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            inflight_q <= '0;
            drop_q     <= '0;
            tag_q      <= '{default: '0};
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            tag_q      <= tag_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    rsp_while_full_a: assert property (@(posedge clk) disable iff (rst)
        !(rsp_accept && fifo_full));

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    // Flushed work is the buffered entries thrown away plus every dropped response.
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_flushed_d = perf_flushed_q;
        if (redirect_valid) begin
            perf_flushed_d = perf_flushed_q + 32'(fifo_count) + 32'(rsp_seen);
        end else if ((state_q == FLUSH) && rsp_seen) begin
            perf_flushed_d = perf_flushed_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model with random latency and
// a queue of expected decode entries derived from the fetch-order rules.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    fetch_entry_t exp_q[$];
    mem_req_t     mem_q[$];
    logic [31:0]  exp_req_addr = 32'h0;
    int           fire_cnt = 0;
    int           pop_cnt = 0;
    int           first_valid_cyc = -1;
    int           rel_cyc = 0;
    int           lat_min = 1;
    int           lat_max = 1;
    bit           redir_prev = 1'b0;
    bit           hold_prev = 1'b0;
    logic [31:0]  hold_addr = 32'h0;

    instr_fetch_unit #(
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
`ifdef IFU_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit redir, input logic [31:0] tgt,
                                 input bit dec_rdy, input bit mem_rdy);
        @(posedge clk);
        #1;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if_ready       = dec_rdy;
        imem_req_ready = mem_rdy;
        // Everything fetched but not yet delivered is now on the wrong path.
        if (redir) begin
            exp_q.delete();
            exp_req_addr = {tgt[31:2], 2'b00};
        end
    endtask

    task automatic resetDut(input bit dec_rdy);
        @(posedge clk);
        #1;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = dec_rdy;
        imem_req_ready = 1'b1;
        mem_q.delete();
        exp_q.delete();
        exp_req_addr    = 32'h0;
        fire_cnt        = 0;
        pop_cnt         = 0;
        first_valid_cyc = -1;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_req_addr", imem_req_addr, 32'h0);
        checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_instr", if_instr, NOP_INSTR);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        rel_cyc = cyc;
        #1;
        checkOutput("boot_req_valid", 32'(imem_req_valid), 32'h0);
    endtask

    // Memory model: in-order responses, one per cycle, once their latency expires.
    initial forever begin
        mem_req_t m;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m              = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data_of(m.addr);
        end
    end

    initial forever begin
        fetch_entry_t e;
        mem_req_t     m;
        @(negedge clk);
        if (rst) begin
            redir_prev = 1'b0;
            hold_prev  = 1'b0;
        end else begin
            if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (redirect_valid) checkOutput("req_suppressed_on_redirect", 32'(imem_req_valid), 32'h0);
            if (redir_prev) checkOutput("if_valid_after_redirect", 32'(if_valid), 32'h0);
            if (hold_prev && !redirect_valid) begin
                checkOutput("req_valid_hold", 32'(imem_req_valid), 32'h1);
                checkOutput("req_addr_hold", imem_req_addr, hold_addr);
            end
            if (if_valid && if_ready && !redirect_valid) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pop: got pc %h expected no instruction", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("if_pc", if_pc, e.pc);
                    checkOutput("if_instr", if_instr, e.instr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                checkOutput("req_addr", imem_req_addr, exp_req_addr);
                e.pc    = exp_req_addr;
                e.instr = data_of(exp_req_addr);
                exp_q.push_back(e);
                m.addr = imem_req_addr;
                m.due  = cyc + int'($urandom_range(lat_max, lat_min));
                mem_q.push_back(m);
                exp_req_addr = exp_req_addr + 32'd4;
                fire_cnt++;
            end
            redir_prev = redirect_valid;
            hold_prev  = imem_req_valid && !imem_req_ready;
            hold_addr  = imem_req_addr;
        end
    end

    initial begin
        int pct;
        bit redir;
        logic [31:0] tgt;

        // Streaming from reset: back-to-back requests, first instruction 3 cycles after release.
        lat_min = 1;
        lat_max = 1;
        resetDut(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
            @(negedge clk);
            checkOutput("t1_req_valid", 32'(imem_req_valid), 32'h1);
            checkOutput("t1_req_addr", imem_req_addr, 32'(i * 4));
        end
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t1_first_valid_delay", 32'(first_valid_cyc - rel_cyc), 32'd3);

        // Decode stalled: credits stop fetch after FIFO_DEPTH requests.
        resetDut(1'b0);
        repeat (12) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t2_fire_count", 32'(fire_cnt), 32'd4);
        checkOutput("t2_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("t2_if_valid", 32'(if_valid), 32'h1);
        checkOutput("t2_if_pc", if_pc, 32'h0);
        checkOutput("t2_if_instr", if_instr, data_of(32'h0));
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t2_if_instr_stable", if_instr, data_of(32'h0));
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect to 0x100 with responses in flight.
        lat_min = 2;
        lat_max = 2;
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t3_flush_no_req", 32'(imem_req_valid), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t3_resume_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("t3_resume_addr", imem_req_addr, 32'h100);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Unaligned redirect target.
        applyStimulus(1'b1, 32'h203, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t4_aligned_addr", imem_req_addr, 32'h200);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Second redirect lands while the first is still flushing.
        lat_min = 3;
        lat_max = 3;
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b1);
        repeat (15) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Fetch PC wraps past the top of the address space.
        lat_min = 1;
        lat_max = 3;
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic with a reset in the middle.
        lat_min = 1;
        lat_max = 4;
        pct     = 70;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) pct = int'($urandom_range(10, 100));
            if (i == 750) resetDut(1'b1);
            redir = ($urandom_range(0, 99) < 4);
            tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus(redir, tgt, $urandom_range(0, 99) < pct, $urandom_range(0, 3) != 0);
        end

        // Drain: memory stops accepting, everything outstanding must reach decode.
        repeat (20) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("drain_exp_empty", 32'(exp_q.size()), 32'h0);
        checkOutput("drain_if_valid", 32'(if_valid), 32'h0);
`ifdef IFU_PERF_EN
        checkOutput("perf_fetched", perf_fetched, 32'(pop_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
